id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Parametrised operand-read/decode pipeline stage that sits between fetch and execute.
- Holds one instruction slot with valid/allowin handshaking.
- Resolves two source operands from the register file or from NUM_FWD prioritised forwarding sources. Blocks on not-yet-available producers.
- Supports flush. Exposes a saturating stall counter and a stall watchdog for debug.

Parameters:
DATA_W, 32, operand/forward data width
REG_AW, 5, register address width; address 0 is hardwired zero
NUM_FWD, 3, number of forwarding sources; index 0 = youngest = highest priority
PAYLOAD_W, 64, opaque per-instruction payload width (pc, decoded controls)
CNT_W, 16, stall counter width
STALL_LIMIT, 64, consecutive blocked cycles that trip the watchdog

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream has an instruction
in_allowin  out  1  stage can accept this cycle
in_payload  in  PAYLOAD_W  opaque payload
in_rs  in  REG_AW  source 1 register
in_rt  in  REG_AW  source 2 register
in_rs_used  in  1  source 1 is read by the instruction
in_rt_used  in  1  source 2 is read by the instruction
out_valid  out  1  instruction and operands valid to execute
out_allowin  in  1  downstream can accept
out_payload  out  PAYLOAD_W  held payload
out_rs_value  out  DATA_W  resolved source 1
out_rt_value  out  DATA_W  resolved source 2
rf_raddr1  out  REG_AW  regfile read address = held rs
rf_raddr2  out  REG_AW  regfile read address = held rt
rf_rdata1  in  DATA_W  regfile data, combinational
rf_rdata2  in  DATA_W  regfile data, combinational
fwd_valid  in  NUM_FWD  source i will write fwd_dest[i]
fwd_ready  in  NUM_FWD  source i data is available now
fwd_dest  in  NUM_FWD*REG_AW  packed destinations, entry i at [i*REG_AW +: REG_AW]
fwd_data  in  NUM_FWD*DATA_W  packed data, entry i at [i*DATA_W +: DATA_W]
flush  in  1  discard held instruction
stall_cnt  out  CNT_W  saturating count of blocked cycles
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, active-high):
  - valid=0; payload, rs, rt and used registers = 0; stall_cnt=0; run counter=0; stall_timeout=0.
  - Resulting outputs: out_valid=0, in_allowin=1, out_payload=0, rf_raddr1/2=0.
  - Asserting reset mid-operation drops the held instruction immediately.
- Capture: on rising edge with in_valid && in_allowin && !flush, the holding registers load in_* and valid<=1.
- Release: if in_allowin && !in_valid, valid<=0.
- Operand resolution (combinational, per source s = held rs or rt):
  - If s==0: value 0, no hazard, forwarding ignored.
  - Otherwise scan i=0..NUM_FWD-1 and take the first i with fwd_valid[i] && fwd_dest[i]==s.
    - If fwd_ready[i]: value = fwd_data[i].
    - If not ready: hazard(s)=1; lower-priority matches are NOT used.
  - No match: value = rf_rdata1 (rs) or rf_rdata2 (rt).
- ready_go = !(hazard(rs)&&rs_used || hazard(rt)&&rt_used). A hazard on an unused source never blocks.
- out_valid = valid && ready_go && !flush.
- in_allowin = !valid || (ready_go && out_allowin) || flush.
- Flush:
  - valid<=0 at the next edge.
  - An in_valid presented in the flush cycle is not captured; upstream is flushed with it.
  - Flush wins over any simultaneous capture or handshake.
- Latency: one cycle from in_* capture to out_valid when no hazard. Throughput is one instruction per cycle.
- Held values stay stable while out_valid && !out_allowin. Operand values re-resolve every cycle, so they may update as forwarding changes.
- stall_cnt increments by 1 on each cycle with valid && !ready_go && !flush. It saturates at all-ones and does not wrap.
- Run counter:
  - Counts consecutive blocked cycles.
  - Clears on any non-blocked cycle.
  - Reaching STALL_LIMIT sets stall_timeout, which stays set until reset.
- Back-pressure (out_allowin=0) is not a stall and is not counted.

Test Plan:
- Reset then idle → out_valid=0, in_allowin=1, stall_cnt=0, stall_timeout=0. Assert reset mid-transfer → out_valid falls with no clock edge.
- Capture rs=5, rt=6; rf_rdata1=0x11, rf_rdata2=0x22; no fwd → next cycle out_valid=1, out_rs_value=0x11, out_rt_value=0x22.
- Forwarding priority: fwd0 and fwd2 both dest=5, ready, data 0xAAAA / 0xCCCC → out_rs_value=0xAAAA. fwd0 dest=5 not ready, fwd1 dest=5 ready → out_valid=0, stall_cnt +1 per cycle until fwd_ready[0]=1.
- Hazard on rt=7 with rt_used=0 → no stall. rs=0 with fwd0 dest=0, not ready → value 0, out_valid=1.
- Hold blocking hazard for 64 cycles → stall_timeout=1 at cycle 64 and stays 1 after the hazard clears. With CNT_W=4, 20 blocked cycles → stall_cnt=15.
- Flush while valid and while in_valid=1 → out_valid=0 that cycle, valid=0 next cycle, new instruction not captured. out_allowin=0 for 3 cycles → out_payload held stable and stall_cnt unchanged.

Source files
------------

// File: rtl/id_operand_stage.sv
// Operand-read stage between fetch and execute: holds one instruction and resolves
// rs/rt from the register file or prioritised forwarding sources. Blocks on unready producers.
module id_operand_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_FWD     = 3,
  parameter int PAYLOAD_W   = 64,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_allowin,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [REG_AW-1:0]         in_rs,
  input  logic [REG_AW-1:0]         in_rt,
  input  logic                      in_rs_used,
  input  logic                      in_rt_used,
  output logic                      out_valid,
  input  logic                      out_allowin,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DATA_W-1:0]         out_rs_value,
  output logic [DATA_W-1:0]         out_rt_value,
  output logic [REG_AW-1:0]         rf_raddr1,
  output logic [REG_AW-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      stall_timeout
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  logic                 vld_p0;
  logic [PAYLOAD_W-1:0] payload_p0;
  logic [REG_AW-1:0]    rs_p0;
  logic [REG_AW-1:0]    rt_p0;
  logic                 rs_used_p0;
  logic                 rt_used_p0;
  logic [RUN_W-1:0]     run_p0;

  logic [DATA_W:0]      rs_res;
  logic [DATA_W:0]      rt_res;
  logic                 ready_go;
  logic                 blocked;

  // Returns {hazard, value}. The first matching source decides, even when it is not ready.
  function automatic logic [DATA_W:0] resolve(
    input logic [REG_AW-1:0]         src,
    input logic [DATA_W-1:0]         rf_val,
    input logic [NUM_FWD-1:0]        f_valid,
    input logic [NUM_FWD-1:0]        f_ready,
    input logic [NUM_FWD*REG_AW-1:0] f_dest,
    input logic [NUM_FWD*DATA_W-1:0] f_data
  );
    logic            hit;
    logic [DATA_W:0] res;
    hit = 1'b0;
    res = {1'b0, rf_val};
    if (src == '0) begin
      res = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && f_valid[i] && (f_dest[i*REG_AW +: REG_AW] == src)) begin
          hit = 1'b1;
          res = f_ready[i] ? {1'b0, f_data[i*DATA_W +: DATA_W]} : {1'b1, rf_val};
        end
      end
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v >= RUN_W'(STALL_LIMIT)) ? v : v + RUN_W'(1);
  endfunction

  // Stage 0 resolve: operands re-evaluated every cycle against live forwarding
  assign rs_res = resolve(rs_p0, rf_rdata1, fwd_valid, fwd_ready, fwd_dest, fwd_data);
  assign rt_res = resolve(rt_p0, rf_rdata2, fwd_valid, fwd_ready, fwd_dest, fwd_data);

  assign ready_go   = !((rs_res[DATA_W] && rs_used_p0) || (rt_res[DATA_W] && rt_used_p0));
  assign blocked    = vld_p0 && !ready_go && !flush;
  assign out_valid  = vld_p0 && ready_go && !flush;
  assign in_allowin = !vld_p0 || (ready_go && out_allowin) || flush;

  assign out_payload  = payload_p0;
  assign out_rs_value = rs_res[DATA_W-1:0];
  assign out_rt_value = rt_res[DATA_W-1:0];
  assign rf_raddr1    = rs_p0;
  assign rf_raddr2    = rt_p0;

  // Stage 0 hold: instruction slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      payload_p0 <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rs_used_p0 <= 1'b0;
      rt_used_p0 <= 1'b0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (in_allowin) begin
        vld_p0 <= in_valid;
      end
      if (in_valid && in_allowin && !flush) begin
        payload_p0 <= in_payload;
        rs_p0      <= in_rs;
        rt_p0      <= in_rt;
        rs_used_p0 <= in_rs_used;
        rt_used_p0 <= in_rt_used;
      end
    end
  end

  // Debug counters: back-pressure alone never counts as blocked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= '0;
      run_p0        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (blocked) begin
        stall_cnt <= sat_inc_cnt(stall_cnt);
        run_p0    <= sat_inc_run(run_p0);
        if (run_p0 >= RUN_W'(STALL_LIMIT - 1)) begin
          stall_timeout <= 1'b1;
        end
      end else begin
        run_p0 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: expected operands are queued at issue and
// compared at each output handshake; a narrow-counter instance checks saturation.
module tb_id_operand_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_allowin;
  logic [63:0] in_payload;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic        in_rs_used;
  logic        in_rt_used;
  logic        out_valid;
  logic        out_allowin;
  logic [63:0] out_payload;
  logic [31:0] out_rs_value;
  logic [31:0] out_rt_value;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [2:0]  fwd_valid;
  logic [2:0]  fwd_ready;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_data;
  logic        flush;
  logic [15:0] stall_cnt;
  logic        stall_timeout;

  logic        s_in_allowin;
  logic        s_out_valid;
  logic [63:0] s_out_payload;
  logic [31:0] s_out_rs_value;
  logic [31:0] s_out_rt_value;
  logic [4:0]  s_rf_raddr1;
  logic [4:0]  s_rf_raddr2;
  logic [3:0]  s_stall_cnt;
  logic        s_stall_timeout;

  logic [31:0] rf_mem [32];

  typedef struct {
    logic [63:0] pl;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          chk_rt;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  id_operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .flush(flush), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  id_operand_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allowin(s_in_allowin), .in_payload(in_payload),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .out_valid(s_out_valid), .out_allowin(out_allowin), .out_payload(s_out_payload),
    .out_rs_value(s_out_rs_value), .out_rt_value(s_out_rt_value),
    .rf_raddr1(s_rf_raddr1), .rf_raddr2(s_rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .flush(flush), .stall_cnt(s_stall_cnt), .stall_timeout(s_stall_timeout)
  );

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output handshake monitor: pops the scoreboard on every accepted transfer
  always @(negedge clk) begin
    if (!reset && out_valid && out_allowin) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_payload), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_payload", out_payload, e.pl);
        chk("sb_rs", 64'(out_rs_value), 64'(e.rs));
        if (e.chk_rt) chk("sb_rt", 64'(out_rt_value), 64'(e.rt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] d, input logic [31:0] v);
    fwd_dest[i*5 +: 5]  = d;
    fwd_data[i*32 +: 32] = v;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0;
    fwd_ready = '0;
    fwd_dest  = '0;
    fwd_data  = '0;
  endtask

  // Presents one instruction, checks it is accepted, returns just after the capture edge
  task automatic issue(input logic [63:0] pl, input logic [4:0] rs, input logic [4:0] rt,
                       input bit rsu, input bit rtu, input bit push,
                       input logic [31:0] ers, input logic [31:0] ert, input bit crt);
    exp_t e;
    in_valid   = 1'b1;
    in_payload = pl;
    in_rs      = rs;
    in_rt      = rt;
    in_rs_used = rsu;
    in_rt_used = rtu;
    if (push) begin
      e.pl = pl; e.rs = ers; e.rt = ert; e.chk_rt = crt;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("issue_allowin", 64'(in_allowin), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'h1234;
    rf_mem[5] = 32'h11;
    rf_mem[6] = 32'h22;
    reset = 1'b1;
    in_valid = 1'b0; in_payload = '0; in_rs = '0; in_rt = '0;
    in_rs_used = 1'b0; in_rt_used = 1'b0;
    out_allowin = 1'b1; flush = 1'b0;
    clear_fwd();

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_allowin", 64'(in_allowin), 64'd1);
    chk("rst_payload", out_payload, 64'd0);
    chk("rst_raddr1", 64'(rf_raddr1), 64'd0);
    chk("rst_raddr2", 64'(rf_raddr2), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("idle_timeout", 64'(stall_timeout), 64'd0);
    tick();

    // Plain regfile read, then back-to-back throughput
    issue(64'hA1, 5'd5, 5'd6, 1, 1, 1, 32'h11, 32'h22, 1);
    @(negedge clk);
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_raddr1", 64'(rf_raddr1), 64'd5);
    tick();
    issue(64'hA2, 5'd1, 5'd2, 1, 1, 1, 32'h1001, 32'h1002, 1);
    issue(64'hA3, 5'd3, 5'd4, 1, 1, 1, 32'h1003, 32'h1004, 1);
    tick();

    // Youngest matching source wins
    fwd_valid = 3'b101; fwd_ready = 3'b111;
    set_fwd(0, 5'd5, 32'hAAAA);
    set_fwd(2, 5'd5, 32'hCCCC);
    issue(64'hB1, 5'd5, 5'd6, 1, 1, 1, 32'hAAAA, 32'h22, 1);
    tick();
    clear_fwd();

    // Unready youngest match blocks even though an older match is ready
    fwd_valid = 3'b011; fwd_ready = 3'b010;
    set_fwd(0, 5'd5, 32'hDDDD);
    set_fwd(1, 5'd5, 32'hBBBB);
    issue(64'hC1, 5'd5, 5'd6, 1, 1, 1, 32'hDDDD, 32'h22, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd0);
      chk("stall_in_allowin", 64'(in_allowin), 64'd0);
      chk("stall_cnt_step", 64'(stall_cnt), 64'(k));
      tick();
    end
    fwd_ready = 3'b011;
    @(negedge clk);
    chk("stall_release_valid", 64'(out_valid), 64'd1);
    chk("stall_cnt_after", 64'(stall_cnt), 64'd3);
    tick();
    clear_fwd();

    // Hazard on an unused source does not block
    fwd_valid = 3'b001; fwd_ready = 3'b000;
    set_fwd(0, 5'd7, 32'hEEEE);
    issue(64'hD1, 5'd6, 5'd7, 1, 0, 1, 32'h22, 32'h0, 0);
    @(negedge clk);
    chk("unused_out_valid", 64'(out_valid), 64'd1);
    tick();

    // Register zero ignores forwarding and regfile contents
    set_fwd(0, 5'd0, 32'hFFFF);
    issue(64'hD2, 5'd0, 5'd6, 1, 1, 1, 32'h0, 32'h22, 1);
    @(negedge clk);
    chk("r0_out_valid", 64'(out_valid), 64'd1);
    chk("r0_stall_cnt", 64'(stall_cnt), 64'd3);
    tick();
    clear_fwd();

    // Watchdog trips after 64 consecutive blocked cycles; narrow counter saturates
    fwd_valid = 3'b001; fwd_ready = 3'b000;
    set_fwd(0, 5'd9, 32'h9999);
    issue(64'hE1, 5'd9, 5'd0, 1, 1, 1, 32'h9999, 32'h0, 1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      @(negedge clk);
      if (k == 12) chk("small_cnt_sat", 64'(s_stall_cnt), 64'd15);
      if (k == 20) chk("small_cnt_nowrap", 64'(s_stall_cnt), 64'd15);
      if (k == 63) chk("wd_not_yet", 64'(stall_timeout), 64'd0);
      if (k == 64) begin
        chk("wd_trip", 64'(stall_timeout), 64'd1);
        chk("wd_stall_cnt", 64'(stall_cnt), 64'd67);
      end
    end
    tick();
    fwd_ready = 3'b001;
    @(negedge clk);
    chk("wd_release_valid", 64'(out_valid), 64'd1);
    chk("wd_cnt_final", 64'(stall_cnt), 64'd68);
    tick();
    clear_fwd();
    tick();
    tick();
    @(negedge clk);
    chk("wd_sticky", 64'(stall_timeout), 64'd1);
    tick();

    // Back-pressure holds the payload and is not counted as a stall
    out_allowin = 1'b0;
    issue(64'hF1, 5'd1, 5'd2, 1, 1, 1, 32'h1001, 32'h1002, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_payload", out_payload, 64'hF1);
      chk("bp_in_allowin", 64'(in_allowin), 64'd0);
      chk("bp_stall_cnt", 64'(stall_cnt), 64'd68);
      tick();
    end
    out_allowin = 1'b1;
    tick();

    // Flush beats a simultaneous capture
    issue(64'h51, 5'd1, 5'd2, 1, 1, 0, 32'h0, 32'h0, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_payload = 64'h52;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_allowin", 64'(in_allowin), 64'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_after_valid", 64'(out_valid), 64'd0);
    chk("flush_no_capture", out_payload, 64'h51);
    tick();

    // Asynchronous reset drops the held instruction without a clock edge
    out_allowin = 1'b0;
    issue(64'h61, 5'd3, 5'd4, 1, 1, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_payload", out_payload, 64'd0);
    chk("async_rst_cnt", 64'(stall_cnt), 64'd0);
    chk("async_rst_timeout", 64'(stall_timeout), 64'd0);
    tick();
    reset = 1'b0;
    out_allowin = 1'b1;
    tick();

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
